// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_port_arbiter.
// The tristate data bus is not part of this bundle; it stays a plain inout
// on the arbiter so its driver sits in exactly one place.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int NUM_CH    = 2
) ();

  // Handshake: a requester raises req[i] (level) with we[i], its address and
  // write data stable, and keeps them there until ack[i] pulses for one cycle.
  // The requester drops req[i] in that ack cycle. Anything the requester
  // changes after its access has been granted has no effect on that access.
  logic [NUM_CH-1:0]           req;
  logic [NUM_CH-1:0]           we;
  logic [NUM_CH*ADDR_SIZE-1:0] req_addr;
  logic [NUM_CH*WORD_SIZE-1:0] req_wdata;
  logic [NUM_CH-1:0]           ack;
  logic [WORD_SIZE-1:0]        rdata;

  // Halt control and status.
  logic                        halt_req;
  logic                        is_halted;
  logic [WORD_SIZE-1:0]        num_fetch;

  // Shared memory-bus strobes and address.
  logic                        readM;
  logic                        writeM;
  logic [ADDR_SIZE-1:0]        address;

  // Arbiter side.
  modport slave (
    input  req, we, req_addr, req_wdata, halt_req,
    output ack, rdata, readM, writeM, address, num_fetch, is_halted
  );

  // Requester / CPU-top side.
  modport master (
    output req, we, req_addr, req_wdata, halt_req,
    input  ack, rdata, readM, writeM, address, num_fetch, is_halted
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Multi-cycle memory-bus controller. Picks the lowest-index requesting
// channel, holds readM/writeM and address for MEM_LATENCY cycles, returns
// a one-cycle ack, counts completed fetch-channel reads and sequences halt.
// Every output comes straight from a flop; data is driven only while writeM.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_SIZE   = 16,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 2,
  parameter int FETCH_CH    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_port_arbiter_if.slave    bus,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic [1:0]           dbg_state
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [CH_W-1:0]      grant_q,     grant_d;
  logic                 we_q,        we_d;
  logic [WORD_SIZE-1:0] wdata_q,     wdata_d;
  logic                 readm_q,     readm_d;
  logic                 writem_q,    writem_d;
  logic [ADDR_SIZE-1:0] address_q,   address_d;
  logic [NUM_CH-1:0]    ack_q,       ack_d;
  logic [WORD_SIZE-1:0] rdata_q,     rdata_d;
  logic [WORD_SIZE-1:0] num_fetch_q, num_fetch_d;
  logic                 halted_q,    halted_d;

  logic                 req_any;
  logic [CH_W-1:0]      pick_idx;

  // Fixed-priority pick: scanning from the top down lets the lowest set index win.
  always_comb begin
    req_any  = 1'b0;
    pick_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        req_any  = 1'b1;
        pick_idx = CH_W'(i);
      end
    end
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    readm_d     = readm_q;
    writem_d    = writem_q;
    address_d   = address_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    num_fetch_d = num_fetch_q;
    halted_d    = halted_q;

    case (state_q)
      S_IDLE: begin
        // A halt request seen here wins over any pending requester.
        if (bus.halt_req) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if (req_any) begin
          grant_d   = pick_idx;
          we_d      = bus.we[pick_idx];
          address_d = bus.req_addr[int'(pick_idx) * ADDR_SIZE +: ADDR_SIZE];
          wdata_d   = bus.req_wdata[int'(pick_idx) * WORD_SIZE +: WORD_SIZE];
          readm_d   = ~bus.we[pick_idx];
          writem_d  = bus.we[pick_idx];
          cnt_d     = CNT_W'(MEM_LATENCY);
          state_d   = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last strobe cycle: capture read data off the bus and close the access.
        if (cnt_q == CNT_W'(1)) begin
          if (!we_q) begin
            rdata_d = data;
          end
          readm_d        = 1'b0;
          writem_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = S_DONE;
        end
      end

      S_DONE: begin
        // The ack cycle; requests are deliberately not sampled here so the
        // requester has a cycle to drop its req.
        if ((grant_q == CH_W'(FETCH_CH)) && !we_q) begin
          num_fetch_d = num_fetch_q + WORD_SIZE'(1);
        end
        state_d = S_IDLE;
      end

      S_HALTED: begin
        readm_d  = 1'b0;
        writem_d = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      readm_q     <= 1'b0;
      writem_q    <= 1'b0;
      address_q   <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      num_fetch_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      readm_q     <= readm_d;
      writem_q    <= writem_d;
      address_q   <= address_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      num_fetch_q <= num_fetch_d;
      halted_q    <= halted_d;
    end
  end

  // The arbiter only drives the shared data bus during a write strobe.
  assign data = writem_q ? wdata_q : {WORD_SIZE{1'bz}};

  assign bus.readM     = readm_q;
  assign bus.writeM    = writem_q;
  assign bus.address   = address_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.num_fetch = num_fetch_q;
  assign bus.is_halted = halted_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table for single and contended
// accesses, then hand-written halt, reset-abort and counter-wrap sequences.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUTs and memory models ----------------
  mem_port_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16), .NUM_CH(2)) bus_a ();
  mem_port_arbiter_if #(.WORD_SIZE(4),  .ADDR_SIZE(16), .NUM_CH(2)) bus_b ();

  wire  [15:0] data_a;
  wire  [3:0]  data_b;
  logic [1:0]  dbg_a;
  logic [1:0]  dbg_b;
  logic [15:0] mem_a [0:255];

  assign data_a = bus_a.readM ? mem_a[bus_a.address[7:0]] : 16'bz;
  assign data_b = bus_b.readM ? (bus_b.address[3:0] ^ 4'h5) : 4'bz;

  mem_port_arbiter #(
    .WORD_SIZE(16), .ADDR_SIZE(16), .NUM_CH(2), .MEM_LATENCY(2), .FETCH_CH(0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .data(data_a), .dbg_state(dbg_a)
  );

  mem_port_arbiter #(
    .WORD_SIZE(4), .ADDR_SIZE(16), .NUM_CH(2), .MEM_LATENCY(1), .FETCH_CH(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .data(data_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] w1;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        c_addr;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic [15:0] nf;
    logic        c_nf;
    logic [15:0] dat;
    logic        c_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic [1:0] req, input logic [1:0] we,
                     input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] w1,
                     input logic rd, input logic wr,
                     input logic [15:0] addr, input logic c_addr,
                     input logic [1:0] ack, input logic [15:0] rdata,
                     input logic [15:0] nf, input logic c_nf,
                     input logic [15:0] dat, input logic c_dat);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.w1 = w1;
    v.rd = rd; v.wr = wr; v.addr = addr; v.c_addr = c_addr;
    v.ack = ack; v.rdata = rdata; v.nf = nf; v.c_nf = c_nf;
    v.dat = dat; v.c_dat = c_dat;
    vecs.push_back(v);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_a(input logic [1:0] req, input logic [1:0] we,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] w1);
    bus_a.req       = req;
    bus_a.we        = we;
    bus_a.req_addr  = {a1, a0};
    bus_a.req_wdata = {w1, 16'h0000};
  endtask

  task automatic chk_idle_a(input string tag, input logic halted);
    chk({tag, "_readM"},     32'(bus_a.readM),     32'(1'b0));
    chk({tag, "_writeM"},    32'(bus_a.writeM),    32'(1'b0));
    chk({tag, "_ack"},       32'(bus_a.ack),       32'(2'b00));
    chk({tag, "_is_halted"}, 32'(bus_a.is_halted), 32'(halted));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
    mem_a[8'h10] = 16'hBEEF;
    mem_a[8'h40] = 16'hA5A5;

    reset_n = 1'b0;
    drive_a(2'b00, 2'b00, 16'h0, 16'h0, 16'h0);
    bus_a.halt_req  = 1'b0;
    bus_b.req       = 2'b00;
    bus_b.we        = 2'b00;
    bus_b.req_addr  = '0;
    bus_b.req_wdata = '0;
    bus_b.halt_req  = 1'b0;

    // Reset held low: everything cleared on both instances.
    @(negedge clk);
    @(negedge clk);
    chk_idle_a("rst_a", 1'b0);
    chk("rst_a_rdata",     32'(bus_a.rdata),     32'(16'h0));
    chk("rst_a_num_fetch", 32'(bus_a.num_fetch), 32'(16'h0));
    chk("rst_a_address",   32'(bus_a.address),   32'(16'h0));
    chk("rst_a_state",     32'(dbg_a),           32'(2'd0));
    chk("rst_b_readM",     32'(bus_b.readM),     32'(1'b0));
    chk("rst_b_ack",       32'(bus_b.ack),       32'(2'b00));
    chk("rst_b_num_fetch", 32'(bus_b.num_fetch), 32'(4'h0));
    reset_n = 1'b1;
    @(negedge clk);

    // Cycle table: each row is checked in its cycle, then its inputs are applied.
    //   req    we     a0     a1     w1      rd wr addr   ca ack    rdata    nf cn dat ..
    row(2'b01, 2'b00, 16'h10, 16'h0, 16'h0,    0, 0, 16'h00, 1, 2'b00, 16'h0000, 0, 1, 0, 0);
    row(2'b01, 2'b00, 16'h10, 16'h0, 16'h0,    1, 0, 16'h10, 1, 2'b00, 16'h0000, 0, 1, 0, 0);
    row(2'b01, 2'b00, 16'h10, 16'h0, 16'h0,    1, 0, 16'h10, 1, 2'b00, 16'h0000, 0, 1, 0, 0);
    row(2'b00, 2'b00, 16'h00, 16'h0, 16'h0,    0, 0, 16'h00, 0, 2'b01, 16'hBEEF, 0, 0, 0, 0);
    row(2'b11, 2'b10, 16'h10, 16'h20, 16'h1234, 0, 0, 16'h00, 0, 2'b00, 16'hBEEF, 1, 1, 0, 0);
    row(2'b11, 2'b10, 16'h10, 16'h20, 16'h1234, 1, 0, 16'h10, 1, 2'b00, 16'hBEEF, 1, 1, 0, 0);
    row(2'b11, 2'b10, 16'h10, 16'h20, 16'h1234, 1, 0, 16'h10, 1, 2'b00, 16'hBEEF, 1, 1, 0, 0);
    row(2'b10, 2'b10, 16'h00, 16'h20, 16'h1234, 0, 0, 16'h00, 0, 2'b01, 16'hBEEF, 1, 0, 0, 0);
    row(2'b10, 2'b10, 16'h00, 16'h20, 16'h1234, 0, 0, 16'h00, 0, 2'b00, 16'hBEEF, 2, 1, 0, 0);
    row(2'b10, 2'b10, 16'h00, 16'h20, 16'h1234, 0, 1, 16'h20, 1, 2'b00, 16'hBEEF, 2, 1, 16'h1234, 1);
    row(2'b10, 2'b10, 16'h00, 16'h20, 16'h1234, 0, 1, 16'h20, 1, 2'b00, 16'hBEEF, 2, 1, 16'h1234, 1);
    row(2'b00, 2'b00, 16'h00, 16'h00, 16'h0,    0, 0, 16'h00, 0, 2'b10, 16'hBEEF, 2, 1, 0, 0);
    row(2'b00, 2'b00, 16'h00, 16'h00, 16'h0,    0, 0, 16'h00, 0, 2'b00, 16'hBEEF, 2, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("row%0d_readM", i),  32'(bus_a.readM),  32'(vecs[i].rd));
      chk($sformatf("row%0d_writeM", i), 32'(bus_a.writeM), 32'(vecs[i].wr));
      chk($sformatf("row%0d_ack", i),    32'(bus_a.ack),    32'(vecs[i].ack));
      chk($sformatf("row%0d_rdata", i),  32'(bus_a.rdata),  32'(vecs[i].rdata));
      if (vecs[i].c_addr)
        chk($sformatf("row%0d_address", i), 32'(bus_a.address), 32'(vecs[i].addr));
      if (vecs[i].c_nf)
        chk($sformatf("row%0d_num_fetch", i), 32'(bus_a.num_fetch), 32'(vecs[i].nf));
      if (vecs[i].c_dat)
        chk($sformatf("row%0d_data", i), 32'(data_a), 32'(vecs[i].dat));
      drive_a(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].w1);
    end

    // Halt raised during a ch1 write: the write finishes, then the block halts.
    drive_a(2'b10, 2'b10, 16'h0, 16'h30, 16'h5555);
    @(negedge clk);
    chk("h_writeM",  32'(bus_a.writeM),  32'(1'b1));
    chk("h_address", 32'(bus_a.address), 32'(16'h30));
    chk("h_data",    32'(data_a),        32'(16'h5555));
    bus_a.halt_req = 1'b1;
    @(negedge clk);
    chk("h_writeM2", 32'(bus_a.writeM), 32'(1'b1));
    @(negedge clk);
    chk("h_ack",       32'(bus_a.ack),       32'(2'b10));
    chk("h_writeM3",   32'(bus_a.writeM),    32'(1'b0));
    chk("h_not_yet",   32'(bus_a.is_halted), 32'(1'b0));
    bus_a.req = 2'b00;
    @(negedge clk);
    chk_idle_a("h_idle", 1'b0);
    chk("h_idle_state", 32'(dbg_a), 32'(2'd0));
    @(negedge clk);
    chk("h_halted",       32'(bus_a.is_halted), 32'(1'b1));
    chk("h_halted_state", 32'(dbg_a),           32'(2'd3));
    bus_a.halt_req = 1'b0;
    drive_a(2'b01, 2'b00, 16'h10, 16'h0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_idle_a($sformatf("h_ignored%0d", c), 1'b1);
    end

    // Asynchronous reset asserted mid-cycle clears outputs before the next edge.
    #2 reset_n = 1'b0;
    #1;
    chk_idle_a("ar", 1'b0);
    chk("ar_num_fetch", 32'(bus_a.num_fetch), 32'(16'h0));
    chk("ar_rdata",     32'(bus_a.rdata),     32'(16'h0));
    @(negedge clk);
    reset_n = 1'b1;

    // Reset pulsed during a read's strobe aborts it with no ack.
    @(negedge clk);
    chk("ab_readM",   32'(bus_a.readM),   32'(1'b1));
    chk("ab_address", 32'(bus_a.address), 32'(16'h10));
    #2 reset_n = 1'b0;
    #1;
    chk("ab_readM_drop", 32'(bus_a.readM),     32'(1'b0));
    chk("ab_ack",        32'(bus_a.ack),       32'(2'b00));
    chk("ab_num_fetch",  32'(bus_a.num_fetch), 32'(16'h0));
    bus_a.req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ab_hold%0d_ack", c),   32'(bus_a.ack),   32'(2'b00));
      chk($sformatf("ab_hold%0d_readM", c), 32'(bus_a.readM), 32'(1'b0));
    end
    reset_n = 1'b1;
    drive_a(2'b01, 2'b00, 16'h40, 16'h0, 16'h0);
    begin : after_abort
      int  strobes;
      bit  got;
      strobes = 0;
      got     = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (bus_a.readM) strobes++;
        if (bus_a.ack != 2'b00) begin
          got = 1'b1;
          chk("ab2_ack",     32'(bus_a.ack),   32'(2'b01));
          chk("ab2_rdata",   32'(bus_a.rdata), 32'(16'hA5A5));
          chk("ab2_strobes", 32'(strobes),     32'(2));
          bus_a.req = 2'b00;
        end
      end
      chk("ab2_ack_seen", 32'(got), 32'(1'b1));
      @(negedge clk);
      chk("ab2_num_fetch", 32'(bus_a.num_fetch), 32'(16'h1));
    end

    // WORD_SIZE=4, MEM_LATENCY=1: 16 back-to-back fetches wrap num_fetch.
    begin : wrap_run
      int acks;
      int strobes;
      int last_ack;
      bit nf_pending;
      bit done6;
      acks       = 0;
      strobes    = 0;
      last_ack   = -1;
      nf_pending = 1'b0;
      done6      = 1'b0;
      bus_b.req      = 2'b01;
      bus_b.we       = 2'b00;
      bus_b.req_addr = {16'h0000, 16'h0007};
      for (int cyc = 0; cyc < 120 && !done6; cyc++) begin
        @(negedge clk);
        if (bus_b.readM) strobes++;
        if (bus_b.ack != 2'b00) begin
          chk($sformatf("w%0d_ack", acks),     32'(bus_b.ack),   32'(2'b01));
          chk($sformatf("w%0d_strobes", acks), 32'(strobes),     32'(1));
          chk($sformatf("w%0d_rdata", acks),   32'(bus_b.rdata), 32'(4'h2));
          if (last_ack >= 0)
            chk($sformatf("w%0d_spacing", acks), 32'(cyc - last_ack), 32'(3));
          last_ack   = cyc;
          strobes    = 0;
          acks++;
          nf_pending = 1'b1;
          if (acks == 16) bus_b.req = 2'b00;
        end else if (nf_pending) begin
          chk($sformatf("w%0d_num_fetch", acks), 32'(bus_b.num_fetch), 32'(acks % 16));
          nf_pending = 1'b0;
          if (acks == 16) done6 = 1'b1;
        end
      end
      chk("w_all_acks", 32'(acks), 32'(16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
